// File: rtl/wave_capture_pkg.sv
// Shared definitions for the waveform capture/display path: default widths and
// the capture FSM state encoding used by wave_capture.
package wave_capture_pkg;

    localparam int WC_SAMPLE_W = 16;
    localparam int WC_DISP_W   = 8;
    localparam int WC_ADDR_W   = 8;

    typedef enum logic [1:0] {
        WC_ARMED  = 2'd0,
        WC_ACTIVE = 2'd1,
        WC_WAIT   = 2'd2
    } wc_state_e;

endpackage

// File: rtl/wave_capture_if.sv
// Sample-in / RAM-write-out bundle between the audio source, wave_capture and the
// ping-pong sample RAM; master is the capture side.
interface wave_capture_if
    import wave_capture_pkg::*;
#(
    parameter int SAMPLE_W = WC_SAMPLE_W,
    parameter int DISP_W   = WC_DISP_W,
    parameter int ADDR_W   = WC_ADDR_W
);
    logic                new_sample_ready;
    logic [SAMPLE_W-1:0] new_sample_in;
    logic                wave_display_idle;
    logic [ADDR_W:0]     write_address;
    logic                write_enable;
    logic [DISP_W-1:0]   write_sample;
    logic                read_index;

    modport master (
        input  new_sample_ready, new_sample_in, wave_display_idle,
        output write_address, write_enable, write_sample, read_index
    );

    modport slave (
        output new_sample_ready, new_sample_in, wave_display_idle,
        input  write_address, write_enable, write_sample, read_index
    );
endinterface

// File: rtl/wave_capture_rising_edge_det.sv
// Single-cycle pulse on a 0->1 transition of a synchronous level input.
module rising_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic rise
);
    logic in_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_q <= 1'b0;
        end else begin
            in_q <= in;
        end
    end

    assign rise = in & ~in_q;
endmodule

// File: rtl/wave_capture.sv
// Trigger on a rising zero crossing (or timeout), write one frame into the RAM half
// the display is not reading, then flip halves at the next display blanking edge.
module wave_capture
    import wave_capture_pkg::*;
#(
    parameter int SAMPLE_W     = WC_SAMPLE_W,
    parameter int DISP_W       = WC_DISP_W,
    parameter int ADDR_W       = WC_ADDR_W,
    parameter int TRIG_TIMEOUT = 1024
) (
    input  logic           clk,
    input  logic           reset,
    wave_capture_if.master bus
);
    localparam int TW = (TRIG_TIMEOUT > 1) ? $clog2(TRIG_TIMEOUT) : 1;

    wc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [TW-1:0]     cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W:0]   wa_q, wa_d;
    logic [DISP_W-1:0] ws_q, ws_d;
    logic              rd_q, rd_d;
    logic              prev_neg_q;
    logic              idle_rise;
    logic              strobe;
    logic              sample_neg;
    logic              timeout_hit;
    logic [DISP_W-1:0] disp;

    rising_edge_det u_idle_edge (
        .clk   (clk),
        .reset (reset),
        .in    (bus.wave_display_idle),
        .rise  (idle_rise)
    );

    assign strobe     = bus.new_sample_ready;
    assign sample_neg = bus.new_sample_in[SAMPLE_W-1];
    // Offset-binary conversion is just the top bits with the sign bit flipped.
    assign disp       = {~bus.new_sample_in[SAMPLE_W-1], bus.new_sample_in[SAMPLE_W-2 -: DISP_W-1]};
    assign timeout_hit = (TRIG_TIMEOUT != 0) && (cnt_q == TW'(TRIG_TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        wa_d    = wa_q;
        ws_d    = ws_q;
        rd_d    = rd_q;
        case (state_q)
            WC_ARMED: begin
                if (strobe) begin
                    if ((prev_neg_q && !sample_neg) || timeout_hit) begin
                        we_d    = 1'b1;
                        wa_d    = {~rd_q, {ADDR_W{1'b0}}};
                        ws_d    = disp;
                        index_d = ADDR_W'(1);
                        cnt_d   = '0;
                        state_d = WC_ACTIVE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            WC_ACTIVE: begin
                if (strobe) begin
                    we_d    = 1'b1;
                    wa_d    = {~rd_q, index_q};
                    ws_d    = disp;
                    index_d = index_q + 1'b1;
                    if (index_q == '1) begin
                        state_d = WC_WAIT;
                    end
                end
            end
            WC_WAIT: begin
                if (idle_rise) begin
                    rd_d    = ~rd_q;
                    state_d = WC_ARMED;
                end
            end
            default: state_d = WC_ARMED;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= WC_ARMED;
            index_q    <= '0;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            wa_q       <= '0;
            ws_q       <= '0;
            rd_q       <= 1'b0;
            prev_neg_q <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            wa_q    <= wa_d;
            ws_q    <= ws_d;
            rd_q    <= rd_d;
            if (strobe) begin
                prev_neg_q <= sample_neg;
            end
        end
    end

    assign bus.write_enable  = we_q;
    assign bus.write_address = wa_q;
    assign bus.write_sample  = ws_q;
    assign bus.read_index    = rd_q;
endmodule

// File: tb/tb_wave_capture.sv
// Directed bench for wave_capture: trigger, full frame, ping-pong flip, timeout,
// asynchronous reset and strobe/idle coincidence.
module tb_wave_capture;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    wave_capture_if #(.SAMPLE_W(16), .DISP_W(8), .ADDR_W(8)) bus ();

    wave_capture #(
        .SAMPLE_W    (16),
        .DISP_W      (8),
        .ADDR_W      (8),
        .TRIG_TIMEOUT(16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-cycle strobe; returns on the negedge after the capturing posedge.
    task automatic strobe(input logic [15:0] s);
        @(negedge clk);
        bus.new_sample_in    = s;
        bus.new_sample_ready = 1'b1;
        @(negedge clk);
        bus.new_sample_ready = 1'b0;
    endtask

    task automatic idle_edge();
        @(negedge clk);
        bus.wave_display_idle = 1'b0;
        @(negedge clk);
        bus.wave_display_idle = 1'b1;
        @(negedge clk);
    endtask

    // Strobes i = first..last as {i, 8'h00}; each must write at {half, i}.
    task automatic ramp(input string name, input logic half, input int first, input int last);
        logic [8:0] ea;
        logic [7:0] ed;
        for (int i = first; i <= last; i++) begin
            strobe({8'(i), 8'h00});
            ea = {half, 8'(i)};
            ed = 8'(i) ^ 8'h80;
            checks++;
            if (bus.write_enable !== 1'b1 || bus.write_address !== ea || bus.write_sample !== ed) begin
                errors++;
                $display("FAIL %s i=%0d: we=%b addr=%h data=%h, expected we=1 addr=%h data=%h",
                         name, i, bus.write_enable, bus.write_address, bus.write_sample, ea, ed);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.new_sample_ready  = 1'b0;
        bus.new_sample_in     = '0;
        bus.wave_display_idle = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.write_enable !== 1'b0 || bus.write_address !== 9'h000 ||
            bus.write_sample !== 8'h00 || bus.read_index !== 1'b0) begin
            errors++;
            $display("FAIL reset: we=%b addr=%h data=%h ri=%b, expected 0/000/00/0",
                     bus.write_enable, bus.write_address, bus.write_sample, bus.read_index);
        end
        reset = 1'b0;
    endtask

    task automatic test_trigger();
        strobe(16'hFF00);
        checks++;
        if (bus.write_enable !== 1'b0) begin
            errors++;
            $display("FAIL trig_neg_no_write: we=%b expected 0", bus.write_enable);
        end
        strobe(16'h0100);
        checks++;
        if (bus.write_enable !== 1'b1 || bus.write_address !== 9'h100 || bus.write_sample !== 8'h81) begin
            errors++;
            $display("FAIL trig_write: we=%b addr=%h data=%h expected 1/100/81",
                     bus.write_enable, bus.write_address, bus.write_sample);
        end
        @(negedge clk);
        checks++;
        if (bus.write_enable !== 1'b0 || bus.write_address !== 9'h100) begin
            errors++;
            $display("FAIL trig_one_cycle: we=%b addr=%h expected 0/100", bus.write_enable, bus.write_address);
        end
    endtask

    task automatic test_frame();
        ramp("frame1", 1'b1, 1, 127);
        @(negedge clk);
        checks++;
        if (bus.write_enable !== 1'b0 || bus.write_address !== 9'h17F || bus.write_sample !== 8'hFF) begin
            errors++;
            $display("FAIL frame_hold: we=%b addr=%h data=%h expected 0/17F/FF",
                     bus.write_enable, bus.write_address, bus.write_sample);
        end
        ramp("frame1", 1'b1, 128, 200);
        // Idle rises while ACTIVE and stays high into WAIT: neither edge may flip.
        bus.wave_display_idle = 1'b1;
        ramp("frame1", 1'b1, 201, 255);
        strobe(16'hFF00);
        checks++;
        if (bus.write_enable !== 1'b0) begin
            errors++;
            $display("FAIL frame_257th: we=%b expected 0", bus.write_enable);
        end
    endtask

    task automatic test_wait_idle();
        repeat (4) @(negedge clk);
        checks++;
        if (bus.read_index !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle_held: ri=%b expected 0", bus.read_index);
        end
        idle_edge();
        checks++;
        if (bus.read_index !== 1'b1) begin
            errors++;
            $display("FAIL wait_toggle: ri=%b expected 1", bus.read_index);
        end
        strobe(16'h0500);
        checks++;
        if (bus.write_enable !== 1'b1 || bus.write_address !== 9'h000 || bus.write_sample !== 8'h85) begin
            errors++;
            $display("FAIL frame2_trig: we=%b addr=%h data=%h expected 1/000/85",
                     bus.write_enable, bus.write_address, bus.write_sample);
        end
        ramp("frame2", 1'b0, 1, 255);
    endtask

    task automatic test_coincident();
        strobe(16'h2000);
        checks++;
        if (bus.write_enable !== 1'b0) begin
            errors++;
            $display("FAIL wait_strobe_no_write: we=%b expected 0", bus.write_enable);
        end
        @(negedge clk);
        bus.wave_display_idle = 1'b0;
        @(negedge clk);
        bus.wave_display_idle = 1'b1;
        bus.new_sample_in     = 16'h8000;
        bus.new_sample_ready  = 1'b1;
        @(negedge clk);
        bus.new_sample_ready  = 1'b0;
        checks++;
        if (bus.write_enable !== 1'b0 || bus.read_index !== 1'b0) begin
            errors++;
            $display("FAIL coincident: we=%b ri=%b expected we=0 ri=0", bus.write_enable, bus.read_index);
        end
        strobe(16'h0100);
        checks++;
        if (bus.write_enable !== 1'b1 || bus.write_address !== 9'h100 || bus.write_sample !== 8'h81) begin
            errors++;
            $display("FAIL coincident_arm: we=%b addr=%h data=%h expected 1/100/81",
                     bus.write_enable, bus.write_address, bus.write_sample);
        end
        ramp("frame3", 1'b1, 1, 255);
    endtask

    task automatic test_async_reset();
        idle_edge();
        checks++;
        if (bus.read_index !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_toggle: ri=%b expected 1", bus.read_index);
        end
        strobe(16'h0100);
        checks++;
        if (bus.write_enable !== 1'b1 || bus.write_address !== 9'h000) begin
            errors++;
            $display("FAIL pre_reset_trig: we=%b addr=%h expected 1/000", bus.write_enable, bus.write_address);
        end
        ramp("pre_reset", 1'b0, 1, 8'h3F);
        // Clock is low here; the next posedge is 5 time units away.
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.write_enable !== 1'b0 || bus.write_address !== 9'h000 ||
            bus.write_sample !== 8'h00 || bus.read_index !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: we=%b addr=%h data=%h ri=%b expected 0/000/00/0",
                     bus.write_enable, bus.write_address, bus.write_sample, bus.read_index);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            strobe(16'h1000);
            checks++;
            if (bus.write_enable !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_no_write: strobe %0d we=%b expected 0", i, bus.write_enable);
            end
        end
    endtask

    task automatic test_timeout();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            strobe(16'h1234);
            checks++;
            if (bus.write_enable !== 1'b0) begin
                errors++;
                $display("FAIL timeout_early: strobe %0d we=%b expected 0", i, bus.write_enable);
            end
        end
        strobe(16'h1234);
        checks++;
        if (bus.write_enable !== 1'b1 || bus.write_address !== 9'h100 || bus.write_sample !== 8'h92) begin
            errors++;
            $display("FAIL timeout_force: we=%b addr=%h data=%h expected 1/100/92",
                     bus.write_enable, bus.write_address, bus.write_sample);
        end
        strobe(16'h1234);
        checks++;
        if (bus.write_enable !== 1'b1 || bus.write_address !== 9'h101 || bus.write_sample !== 8'h92) begin
            errors++;
            $display("FAIL timeout_next: we=%b addr=%h data=%h expected 1/101/92",
                     bus.write_enable, bus.write_address, bus.write_sample);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_trigger();
        test_frame();
        test_wait_idle();
        test_coincident();
        test_async_reset();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
